pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generalised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries NUM_FIELDS words of DATA_WIDTH bits plus a valid bit, with a valid/ready handshake.
//  Adds stall back-pressure and synchronous flush (bubble insertion) for hazard and branch handling.
//  Optional skid slot breaks the combinational ready path for timing.
// PARAMETERS
//  DATA_WIDTH  32  width of each payload field
//  NUM_FIELDS  2   payload fields per entry (e.g. ALU result, store data)
// PORTS
//  clk        in   1                      rising-edge clock
//  rst_n      in   1                      asynchronous, active-low reset
//  flush_i    in   1                      synchronous flush: discard all held entries
//  in_valid   in   1                      upstream entry valid
//  in_ready   out  1                      stage can accept this cycle
//  in_data    in   NUM_FIELDS*DATA_WIDTH  upstream payload; field k = [k*DATA_WIDTH +: DATA_WIDTH]
//  out_valid  out  1                      output entry valid
//  out_ready  in   1                      downstream accepts this cycle
//  out_data   out  NUM_FIELDS*DATA_WIDTH  registered payload
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): out_valid=0, out_data=0, skid entry invalid.
//    in_ready after reset: 1.
//  - Transfer rules: in-side transfer when in_valid&&in_ready; out-side transfer when out_valid&&out_ready.
//    Both sampled at posedge clk.
//  - Latency: 1 cycle from in-side transfer to out_valid (empty stage). Throughput: 1 entry/cycle
//    with out_ready held high.
//  - Main register states: EMPTY, FULL.
//    EMPTY + in xfer -> FULL, out_data<=in_data.
//    FULL + out xfer + in xfer -> FULL, new data.
//    FULL + out xfer, no in -> EMPTY, out_data holds last value.
//    FULL + no out xfer -> hold (stall): out_data and out_valid stable until accepted.
//  - Flush: on posedge with flush_i=1, every entry is invalidated (out_valid=0 next cycle), regardless of
//    concurrent in/out transfers.
//    An in-side transfer in the flush cycle is discarded. flush_i has priority over all else.
//    out_data not cleared on flush.
//  - out_data never changes while out_valid=1 && out_ready=0 (AXI-style stability). in_valid may drop freely.
//  - Reset asserted mid-operation: all entries lost immediately; no partial transfer completes.
// CONFIGURATION
//  - Macro PIPE_STAGE_SKID_EN.
//  - Defined: adds one skid entry; states EMPTY, FULL, FULL_SKID.
//    in_ready = !skid_valid (registered, no path from out_ready).
//    FULL + in xfer + no out xfer -> FULL_SKID (data captured in skid).
//    FULL_SKID + out xfer -> FULL, main<=skid.
//    in_ready=0 in FULL_SKID. Flush clears skid too.
//  - Not defined: no skid; in_ready = !out_valid || out_ready (combinational). States EMPTY/FULL only.
//  - Cycle-level output sequence identical in both builds for any out_ready pattern. Skid only changes
//    in_ready timing.
// STRUCTURE
//  - pipe_pkg: typedef logic [DATA_WIDTH-1:0] word_t default, enum pipe_state_e {EMPTY,FULL,FULL_SKID}.
//  - pipe_pkg: localparam PIPE_DEF_FIELDS=2.
//  - Sub-module pipe_skid_slot (single data+valid entry with load/clear), instantiated only under
//    PIPE_STAGE_SKID_EN.
//  - Top holds state register, main payload register, handshake logic.
// TESTING
//  - Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0 same cycle (async);
//    in_ready=1 after release.
//  - Streaming: in_data={32'h1,32'h2},{3,4},{5,6} back-to-back, out_ready=1.
//    -> out_data same order, out_valid high 3 consecutive cycles, 1-cycle latency.
//  - Stall: FULL with 32'hDEAD_BEEF, out_ready=0 for 4 cycles -> out_data stable, out_valid=1.
//    Skid build: second input captured, in_ready=0. Release -> both delivered in order.
//  - Flush: flush_i=1 while FULL and in_valid=1 with 32'hCAFE -> next cycle out_valid=0, 32'hCAFE
//    never appears on output.
//  - Simultaneous: FULL, out_ready=1, in_valid=1 same cycle -> stays FULL with new data, no bubble.
//  - Random: random in_valid/out_ready/flush over 10k cycles vs. scoreboard queue.
//    Zero loss/duplication, order kept. Run with and without PIPE_STAGE_SKID_EN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage register.
// Optional skid entry is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;

    localparam int PIPE_DEF_WIDTH  = 32;
    localparam int PIPE_DEF_FIELDS = 2;

    typedef logic [PIPE_DEF_WIDTH-1:0] word_t;

    // FULL_SKID is only reachable when the skid entry is built in.
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_SKID = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single data+valid holding entry with load and clear; clear wins over load.
// Instantiated by pipe_stage_reg only when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int W = 2 * PIPE_DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with stall back-pressure and synchronous flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry that registers in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = PIPE_DEF_WIDTH,
    parameter int NUM_FIELDS = PIPE_DEF_FIELDS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data
);

    localparam int W = NUM_FIELDS * DATA_WIDTH;

    pipe_state_e  state_q;
    logic [W-1:0] data_q;
    logic         in_xfer;
    logic         out_xfer;

    // Handshake: a side transfers on a rising edge where its valid and ready
    // are both high; valid never waits for ready, and held output data stays
    // stable until accepted.
    assign out_valid = (state_q != EMPTY);
    assign out_data  = data_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [W-1:0] skid_data;

    // Ready depends only on registered state, cutting the out_ready->in_ready path.
    assign in_ready   = !skid_valid;
    assign skid_load  = !flush_i && (state_q == FULL) && in_xfer && !out_xfer;
    assign skid_clear = flush_i || ((state_q == FULL_SKID) && out_xfer);

    pipe_skid_slot #(.W(W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .valid (skid_valid),
        .q     (skid_data)
    );
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_q <= FULL;
                        data_q  <= in_data;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        if (in_xfer) data_q <= in_data;
                        else         state_q <= EMPTY;
                    end else if (in_xfer) begin
                        state_q <= FULL_SKID;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL_SKID: begin
                    if (out_xfer) begin
                        state_q <= FULL;
                        data_q  <= skid_data;
                    end
                end
`endif
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand sequences, random vs. queue model.
// Honours PIPE_STAGE_SKID_EN for in_ready expectations.
module tb_pipe_stage_reg;

  localparam int W = 64;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_fail = 0;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush_i   = fl;
  endtask

  // vector table
  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         exp_ir;
    logic         exp_ov;
    logic [W-1:0] exp_od;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [W-1:0] d, logic ordy, logic fl,
                              logic eir, logic eov, logic [W-1:0] eod);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.exp_ir = eir; v.exp_ov = eov; v.exp_od = eod;
    return v;
  endfunction

  vec_t vecs[10];

  // scoreboard / model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out;

  localparam logic [W-1:0] D_DEAD = {32'h0, 32'hDEAD_BEEF};
  localparam logic [W-1:0] D_NEXT = {32'h0, 32'h0000_0002};
  localparam logic [W-1:0] D_CAFE = {32'hCAFE, 32'hCAFE};

  initial begin
    // reset state
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming, back-to-back with simultaneous in/out, flush while full
    vecs[0] = mk(1, {32'h1, 32'h2}, 1, 0, 1, 1, {32'h1, 32'h2});
    vecs[1] = mk(1, {32'h3, 32'h4}, 1, 0, 1, 1, {32'h3, 32'h4});
    vecs[2] = mk(1, {32'h5, 32'h6}, 1, 0, 1, 1, {32'h5, 32'h6});
    vecs[3] = mk(0, '0,             1, 0, 1, 0, {32'h5, 32'h6});
    vecs[4] = mk(1, {32'h7, 32'h8}, 0, 0, 1, 1, {32'h7, 32'h8});
    vecs[5] = mk(1, {32'h9, 32'hA}, 1, 0, 1, 1, {32'h9, 32'hA});
    vecs[6] = mk(0, '0,             1, 0, 1, 0, {32'h9, 32'hA});
    vecs[7] = mk(1, D_DEAD,         0, 0, 1, 1, D_DEAD);
    vecs[8] = mk(1, D_CAFE,         0, 1, SKID, 0, D_DEAD);
    vecs[9] = mk(0, '0,             1, 0, 1, 0, D_DEAD);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      #1;
      check($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].exp_ir});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_ov});
      check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
    end

    // stall: hold DEAD_BEEF four cycles with a second entry pending
    @(negedge clk);
    drive(1, D_DEAD, 0, 0);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, D_NEXT, 0, 0);
      #1;
      check($sformatf("stall%0d_in_ready", c), {63'd0, in_ready}, {63'd0, (SKID && c == 0)});
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_out_valid", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("stall%0d_out_data", c), out_data, D_DEAD);
    end
    @(negedge clk);
    drive(1, D_NEXT, 1, 0);
    @(posedge clk);
    #1;
    check("release_out_valid", {63'd0, out_valid}, 64'd1);
    check("release_out_data", out_data, D_NEXT);
    @(negedge clk);
    drive(0, '0, 1, 0);
    @(posedge clk);
    #1;
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
    check("drain_out_data", out_data, D_NEXT);

    // asynchronous reset mid-stream while holding an entry
    @(negedge clk);
    drive(1, D_CAFE, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_out_data", out_data, 64'd0);
    @(negedge clk);
    drive(0, '0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    // random traffic against a FIFO-of-capacity model
    exp_q.delete();
    last_out = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic iv, ordy, fl, eir, ix, ox;
      logic [W-1:0] d;
      @(negedge clk);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      d    = {$urandom, $urandom};
      drive(iv, d, ordy, fl);
      #1;
      eir = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
      check("rand_in_ready", {63'd0, in_ready}, {63'd0, eir});
      check("rand_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      check("rand_out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : last_out);
      ix = iv && eir;
      ox = (exp_q.size() != 0) && ordy;
      if (fl) begin
        if (exp_q.size() != 0) last_out = exp_q[0];
        exp_q.delete();
      end else begin
        if (ox) last_out = exp_q.pop_front();
        if (ix) exp_q.push_back(d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
